fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/mips_pkg.sv | 15 +
 rtl/fetch_stage_if.sv | 29 ++
 rtl/fetch_queue.sv | 62 ++++++
 rtl/fetch_stage.sv | 84 ++++++++
 tb/tb_fetch_stage.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS front-end constants: instruction width, reset PC and PC stepping.
package mips_pkg;

  localparam int          INSTR_WIDTH      = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;

  typedef logic [31:0] pc_t;

  // Branch targets are word-aligned by dropping the byte offset.
  function automatic pc_t align_pc(input pc_t pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: redirect input, instruction-memory port, decode handshake.
interface fetch_stage_if
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = INSTR_WIDTH
);

  logic                  redirect_valid;
  pc_t                   redirect_pc;
  logic                  imem_en;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_rd_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_instr;
  pc_t                   out_pc;

  modport master (
    input  redirect_valid, redirect_pc, imem_rd_data, out_ready,
    output imem_en, imem_addr, out_valid, out_instr, out_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_rd_data, out_ready,
    input  imem_en, imem_addr, out_valid, out_instr, out_pc
  );

endinterface

// File: rtl/fetch_queue.sv
// Circular FIFO holding fetched {pc, instruction} pairs; flush empties it in one edge.
module fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_b,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = cnt;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries data only; occupancy and pointers decide what is live.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: credit-limited sequential fetch into a small queue, with redirect flush.
module fetch_stage
  import mips_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 10,
  parameter int          DATA_WIDTH  = INSTR_WIDTH,
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_b,
  fetch_stage_if.master bus
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
  localparam int ENT_W = 32 + DATA_WIDTH;

  pc_t              fetch_pc;
  pc_t              pc_p1;
  logic             vld_p1;
  logic             issue;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] q_count;
  logic             q_full;
  logic             q_empty;
  logic [ENT_W-1:0] q_head;

  // Credit counts only registered state, so out_ready never reaches imem_en.
  always_comb begin
    issue = 1'b0;
    if (reset_b && !bus.redirect_valid && !q_full) begin
      issue = (int'(q_count) + int'(vld_p1)) < QUEUE_DEPTH;
    end
  end

  assign push = vld_p1 && !bus.redirect_valid;
  assign pop  = !q_empty && bus.out_ready;

  // ---- stage 0: issue to instruction memory ----
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      fetch_pc <= RESET_PC;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= issue;
      if (bus.redirect_valid) begin
        fetch_pc <= align_pc(bus.redirect_pc);
      end else if (issue) begin
        fetch_pc <= fetch_pc + PC_INCR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) pc_p1 <= fetch_pc;
  end

  // ---- stage 1: memory response enters the queue ----
  fetch_queue #(
    .WIDTH (ENT_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset_b   (reset_b),
    .flush     (bus.redirect_valid),
    .push      (push),
    .push_data ({pc_p1, bus.imem_rd_data}),
    .pop       (pop),
    .rd_data   (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign bus.imem_en   = issue;
  assign bus.imem_addr = fetch_pc[ADDR_WIDTH+1:2];
  assign bus.out_valid = !q_empty;

  // Head fields read as zero whenever nothing is queued, including during reset.
  assign bus.out_pc    = q_empty ? '0 : q_head[DATA_WIDTH +: 32];
  assign bus.out_instr = q_empty ? '0 : q_head[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Scenario bench for fetch_stage with a stream scoreboard over the decode handshake.
module tb_fetch_stage;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int QD = 4;

  logic clk = 1'b0;
  logic reset_b;
  int   checks = 0;
  int   errors = 0;
  int   n_accept = 0;

  logic [63:0] exp_q[$];
  logic [31:0] sb_tail;
  logic        hold_vld = 1'b0;
  logic [31:0] hold_pc;
  logic [31:0] hold_instr;

  always #5 clk = ~clk;

  fetch_stage_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  fetch_stage #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .QUEUE_DEPTH(QD),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk     (clk),
    .reset_b (reset_b),
    .bus     (bus)
  );

  // Instruction memory: word at address a holds a*4, returned one cycle after issue.
  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_rd_data <= {20'b0, bus.imem_addr, 2'b00};
  end

  function automatic logic [63:0] exp_entry(input logic [31:0] pc);
    return {pc, 20'b0, pc[11:2], 2'b00};
  endfunction

  function automatic void sb_restart(input logic [31:0] pc);
    exp_q.delete();
    sb_tail = pc;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(exp_entry(sb_tail));
      sb_tail = sb_tail + 32'd4;
    end
  endfunction

  // Every accepted head must be the next PC of the current stream; a stalled head must not move.
  always @(negedge clk) begin
    logic [63:0] e;
    if (!reset_b) begin
      hold_vld = 1'b0;
    end else begin
      if (hold_vld) begin
        checks++;
        if (!bus.out_valid || bus.out_pc !== hold_pc || bus.out_instr !== hold_instr) begin
          errors++;
          $display("FAIL hold_stable: got v=%b pc=%h instr=%h expected pc=%h instr=%h",
                   bus.out_valid, bus.out_pc, bus.out_instr, hold_pc, hold_instr);
        end
      end
      if (bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
        e = exp_q.pop_front();
        exp_q.push_back(exp_entry(sb_tail));
        sb_tail = sb_tail + 32'd4;
        n_accept++;
        checks++;
        if ({bus.out_pc, bus.out_instr} !== e) begin
          errors++;
          $display("FAIL stream: got pc=%h instr=%h expected pc=%h instr=%h",
                   bus.out_pc, bus.out_instr, e[63:32], e[31:0]);
        end
      end
      hold_vld   = bus.out_valid && !bus.out_ready && !bus.redirect_valid;
      hold_pc    = bus.out_pc;
      hold_instr = bus.out_instr;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_b            = 1'b0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    step();
    step();
    @(negedge clk);
    checks++; if (bus.imem_en !== 1'b0) begin errors++; $display("FAIL reset_imem_en: got %b expected 0", bus.imem_en); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc: got %h expected 0", bus.out_pc); end
    checks++; if (bus.out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr: got %h expected 0", bus.out_instr); end
    step();
  endtask

  task automatic test_stream();
    sb_restart(32'h0);
    bus.out_ready = 1'b1;
    reset_b       = 1'b1;
    @(negedge clk);
    checks++; if (bus.imem_en !== 1'b1 || bus.imem_addr !== 10'h000) begin
      errors++; $display("FAIL first_issue: got en=%b addr=%h expected en=1 addr=000", bus.imem_en, bus.imem_addr);
    end
    step();
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL early_valid: got %b expected 0", bus.out_valid); end
    for (int k = 0; k < 4; k++) begin
      step();
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(4*k) || bus.out_instr !== 32'(4*k)) begin
        errors++;
        $display("FAIL stream_head%0d: got v=%b pc=%h instr=%h expected pc=%h", k,
                 bus.out_valid, bus.out_pc, bus.out_instr, 32'(4*k));
      end
    end
    for (int k = 0; k < 16; k++) begin
      step();
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL throughput: cycle %0d got valid=%b expected 1", k, bus.out_valid); end
    end
    step();
  endtask

  task automatic test_backpressure();
    int issues;
    bus.out_ready = 1'b0;
    reset_b       = 1'b0;
    sb_restart(32'h0);
    step();
    step();
    reset_b = 1'b1;
    issues  = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.imem_en) issues++;
      step();
    end
    checks++; if (issues !== QD) begin errors++; $display("FAIL bp_issue_count: got %0d expected %0d", issues, QD); end
    @(negedge clk);
    checks++; if (bus.imem_en !== 1'b0) begin errors++; $display("FAIL bp_imem_en: got %b expected 0", bus.imem_en); end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0) begin
      errors++; $display("FAIL bp_head: got v=%b pc=%h expected v=1 pc=0", bus.out_valid, bus.out_pc);
    end
    step();
  endtask

  task automatic test_redirect();
    bus.out_ready = 1'b1;
    @(negedge clk);
    step();
    bus.out_ready = 1'b0;
    @(negedge clk);
    checks++; if (bus.imem_en !== 1'b1 || bus.imem_addr !== 10'h004) begin
      errors++; $display("FAIL rd_refill_issue: got en=%b addr=%h expected en=1 addr=004", bus.imem_en, bus.imem_addr);
    end
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0103;
    sb_restart(32'h0000_0100);
    @(negedge clk);
    checks++; if (bus.imem_en !== 1'b0) begin errors++; $display("FAIL rd_suppress: got %b expected 0", bus.imem_en); end
    step();
    bus.redirect_valid = 1'b0;
    bus.out_ready      = 1'b1;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rd_flush: got valid=%b expected 0", bus.out_valid); end
    checks++; if (bus.imem_en !== 1'b1 || bus.imem_addr !== 10'h040) begin
      errors++; $display("FAIL rd_target_addr: got en=%b addr=%h expected en=1 addr=040", bus.imem_en, bus.imem_addr);
    end
    step();
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rd_squash: got valid=%b pc=%h expected 0", bus.out_valid, bus.out_pc); end
    step();
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0000_0100) begin
      errors++; $display("FAIL rd_target_pc: got v=%b pc=%h expected v=1 pc=00000100", bus.out_valid, bus.out_pc);
    end
    step();
  endtask

  task automatic test_wrap();
    logic [AW-1:0] ea;
    bit found;
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0FF0;
    sb_restart(32'h0000_0FF0);
    @(negedge clk);
    step();
    bus.redirect_valid = 1'b0;
    ea = 10'h3FC;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.imem_en !== 1'b1 || bus.imem_addr !== ea) begin
        errors++; $display("FAIL wrap_addr%0d: got en=%b addr=%h expected en=1 addr=%h", i, bus.imem_en, bus.imem_addr, ea);
      end
      ea = ea + 10'd1;
      step();
    end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_pc === 32'h0000_1000 && bus.out_instr === 32'h0) found = 1'b1;
      step();
    end
    checks++; if (!found) begin errors++; $display("FAIL wrap_pc: got no head pc=00001000 within 10 cycles, expected one"); end
  endtask

  task automatic test_async_reset();
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0200;
    sb_restart(32'h0000_0200);
    @(negedge clk);
    step();
    bus.redirect_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL ar_prefill: got valid=%b expected 1", bus.out_valid); end
    #2;
    reset_b = 1'b0;
    sb_restart(32'h0);
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.imem_en !== 1'b0) begin
      errors++; $display("FAIL ar_immediate: got valid=%b en=%b expected 0 0", bus.out_valid, bus.imem_en);
    end
    checks++; if (bus.out_pc !== 32'h0 || bus.out_instr !== 32'h0) begin
      errors++; $display("FAIL ar_zero_head: got pc=%h instr=%h expected 0 0", bus.out_pc, bus.out_instr);
    end
    step();
    step();
    reset_b       = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.imem_en !== 1'b1 || bus.imem_addr !== 10'h000) begin
      errors++; $display("FAIL ar_restart: got en=%b addr=%h expected en=1 addr=000", bus.imem_en, bus.imem_addr);
    end
    step();
    step();
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0) begin
      errors++; $display("FAIL ar_first_out: got v=%b pc=%h expected v=1 pc=0", bus.out_valid, bus.out_pc);
    end
    step();
  endtask

  task automatic test_random();
    int start;
    logic [31:0] tgt;
    start = n_accept;
    for (int c = 0; c < 10000; c++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 31) == 0) begin
        tgt                = 32'($urandom_range(0, 16383));
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = tgt;
        sb_restart(tgt & 32'hFFFF_FFFC);
      end else begin
        bus.redirect_valid = 1'b0;
      end
      step();
    end
    bus.redirect_valid = 1'b0;
    bus.out_ready      = 1'b1;
    for (int c = 0; c < 10; c++) step();
    checks++; if (n_accept - start < 3000) begin
      errors++; $display("FAIL random_progress: got %0d accepted expected at least 3000", n_accept - start);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion within time limit, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
